// File: rtl/pattern_sequencer.sv
// Raster-scan coordinate sequencer for a test-pattern generator.
// Walks (hcount, vcount) over a frame under valid/ready and steps the pattern select between frames.
module pattern_sequencer #(
  parameter int unsigned HRES               = 1280,
  parameter int unsigned VRES               = 720,
  parameter int unsigned FRAMES_PER_PATTERN = 60
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic                    stop_in,
  input  logic                    advance_in,
  input  logic                    auto_en_in,
  input  logic                    ready_in,
  output logic                    valid_out,
  output logic [$clog2(HRES)-1:0] hcount_out,
  output logic [$clog2(VRES)-1:0] vcount_out,
  output logic [1:0]              sel_out,
  output logic                    frame_done_out,
  output logic                    busy_out
);

  localparam int unsigned HW = $clog2(HRES);
  localparam int unsigned VW = $clog2(VRES);

  localparam logic [HW-1:0] HLast  = HW'(HRES - 1);
  localparam logic [VW-1:0] VLast  = VW'(VRES - 1);
  localparam logic [16:0]   FppCnt = 17'(FRAMES_PER_PATTERN);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StFrameEnd
  } state_e;

  state_e        state_q, state_d;
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          adv_pend_q, adv_pend_d;
  logic          stop_pend_q, stop_pend_d;

  logic [16:0]   frame_inc;
  logic          auto_adv;

  always_comb begin
    state_d     = state_q;
    hcount_d    = hcount_q;
    vcount_d    = vcount_q;
    sel_d       = sel_q;
    frame_cnt_d = frame_cnt_q;
    adv_pend_d  = adv_pend_q;
    stop_pend_d = stop_pend_q;
    frame_inc   = {1'b0, frame_cnt_q} + 17'd1;
    auto_adv    = 1'b0;

    case (state_q)
      StIdle: begin
        // In idle an advance takes effect at once so a pattern can be picked before starting.
        if (advance_in) begin
          sel_d       = sel_q + 2'd1;
          frame_cnt_d = '0;
        end
        if (start_in) begin
          state_d     = StScan;
          hcount_d    = '0;
          vcount_d    = '0;
          stop_pend_d = stop_in;
        end
      end

      StScan: begin
        if (advance_in) adv_pend_d = 1'b1;
        if (stop_in)    stop_pend_d = 1'b1;
        if (ready_in) begin
          if (hcount_q == HLast) begin
            hcount_d = '0;
            if (vcount_q == VLast) begin
              vcount_d = '0;
              state_d  = StFrameEnd;
            end else begin
              vcount_d = vcount_q + VW'(1);
            end
          end else begin
            hcount_d = hcount_q + HW'(1);
          end
        end
      end

      StFrameEnd: begin
        if (frame_inc == FppCnt) begin
          frame_cnt_d = '0;
          auto_adv    = auto_en_in;
        end else begin
          frame_cnt_d = frame_inc[15:0];
        end
        // Manual and auto advances at the same boundary merge into one step.
        if (adv_pend_q || advance_in || auto_adv) begin
          sel_d       = sel_q + 2'd1;
          frame_cnt_d = '0;
        end
        adv_pend_d  = 1'b0;
        stop_pend_d = 1'b0;
        state_d     = (stop_pend_q || stop_in) ? StIdle : StScan;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      hcount_q    <= '0;
      vcount_q    <= '0;
      sel_q       <= '0;
      frame_cnt_q <= '0;
      adv_pend_q  <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      sel_q       <= sel_d;
      frame_cnt_q <= frame_cnt_d;
      adv_pend_q  <= adv_pend_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign valid_out      = (state_q == StScan);
  assign frame_done_out = (state_q == StFrameEnd);
  assign busy_out       = (state_q != StIdle);
  assign hcount_out     = hcount_q;
  assign vcount_out     = vcount_q;
  assign sel_out        = sel_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Randomized bench for pattern_sequencer on a 4x2 frame, checked every cycle
// against a pixel-index / pattern-count reference model.
module tb_pattern_sequencer;

  localparam int unsigned HRES = 4;
  localparam int unsigned VRES = 2;
  localparam int unsigned FPP  = 2;

  logic       clk = 1'b0;
  logic       rst, start, stop, adv, auto_en, ready;
  logic       valid, fdone, busy;
  logic [1:0] hcount;
  logic [0:0] vcount;
  logic [1:0] sel;

  always #5 clk = ~clk;

  pattern_sequencer #(
    .HRES              (HRES),
    .VRES              (VRES),
    .FRAMES_PER_PATTERN(FPP)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .start_in      (start),
    .stop_in       (stop),
    .advance_in    (adv),
    .auto_en_in    (auto_en),
    .ready_in      (ready),
    .valid_out     (valid),
    .hcount_out    (hcount),
    .vcount_out    (vcount),
    .sel_out       (sel),
    .frame_done_out(fdone),
    .busy_out      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 = idle, 1 = scanning pixel m_pix of the frame, 2 = the gap after a frame.
  int m_mode, m_pix, m_sel, m_frames;
  bit m_adv_req, m_stop_req;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pix = 0; m_sel = 0; m_frames = 0;
    m_adv_req = 1'b0; m_stop_req = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit ad, input bit ae,
                            input bit rd);
    bit auto_due;
    if (m_mode == 0) begin
      if (ad) begin
        m_sel    = (m_sel + 1) % 4;
        m_frames = 0;
      end
      if (st) begin
        m_mode     = 1;
        m_pix      = 0;
        m_stop_req = sp;
      end
    end else begin
      if (ad) m_adv_req = 1'b1;
      if (sp) m_stop_req = 1'b1;
      if (m_mode == 1) begin
        if (rd) begin
          m_pix++;
          if (m_pix == HRES * VRES) begin
            m_pix  = 0;
            m_mode = 2;
          end
        end
      end else begin
        m_frames++;
        auto_due = 1'b0;
        if (m_frames == FPP) begin
          m_frames = 0;
          auto_due = ae;
        end
        if (m_adv_req || auto_due) begin
          m_sel    = (m_sel + 1) % 4;
          m_frames = 0;
        end
        m_adv_req  = 1'b0;
        m_mode     = m_stop_req ? 0 : 1;
        m_stop_req = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("valid", int'(valid), int'(m_mode == 1));
    check_eq("busy", int'(busy), int'(m_mode != 0));
    check_eq("frame_done", int'(fdone), int'(m_mode == 2));
    check_eq("sel", int'(sel), m_sel);
    if (m_mode == 1) begin
      check_eq("hcount", int'(hcount), m_pix % HRES);
      check_eq("vcount", int'(vcount), m_pix / HRES);
    end
  endtask

  task automatic step(input bit st, input bit sp, input bit ad, input bit ae, input bit rd);
    @(negedge clk);
    check_outputs();
    start = st; stop = sp; adv = ad; auto_en = ae; ready = rd;
    @(posedge clk);
    model_step(st, sp, ad, ae, rd);
  endtask

  // Percent probabilities per input; ae = 2 means auto_en toggles randomly.
  task automatic run(input int n, input int p_st, input int p_sp, input int p_ad, input int ae,
                     input int p_rd);
    for (int i = 0; i < n; i++) begin
      step($urandom_range(99) < p_st, $urandom_range(99) < p_sp, $urandom_range(99) < p_ad,
           (ae == 2) ? bit'($urandom_range(1)) : bit'(ae), $urandom_range(99) < p_rd);
    end
  endtask

  // Asserts reset between clock edges and checks the outputs before the next edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 model_reset();
    check_outputs();
    check_eq("rst_hcount", int'(hcount), 0);
    check_eq("rst_vcount", int'(vcount), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; adv = 1'b0; auto_en = 1'b0; ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst = 1'b0;

    // Full-rate scan: 8 coordinates in order then one bubble per frame.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run(30, 0, 0, 0, 0, 100);
    // Back-pressure.
    run(60, 0, 0, 0, 0, 50);
    // Auto advance every 2nd frame, then with manual pulses landing on auto boundaries.
    run(100, 0, 0, 0, 1, 100);
    run(120, 0, 0, 15, 1, 100);
    // Mid-frame stop: frame completes then idle.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    run(20, 0, 0, 0, 0, 80);
    // Pattern pick in idle, then start together with stop for a single frame.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    run(15, 0, 0, 0, 0, 100);
    // Everything random.
    run(3000, 6, 3, 4, 2, 70);

    // Async reset at (2,1) with sel = 2, then a clean restart.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (m_mode == 1 && m_pix == 6) break;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check_eq("reach_pix_2_1", m_pix, 6);
    check_eq("sel_before_rst", int'(sel), 2);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    run(12, 0, 0, 0, 0, 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
